// File: rtl/instr_field_encoder_pkg.sv
// Shared definitions for the instruction field encoder: format codes, FSM states,
// MIPS field positions and the word-packing helper.
package instr_field_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R     = 2'd0,
    FMT_SHIFT = 2'd1,
    FMT_I     = 2'd2,
    FMT_J     = 2'd3
  } fmt_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPack   = 3'd1,
    StWrite  = 3'd2,
    StErr    = 3'd3,
    StVerify = 3'd4
  } state_e;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned SH_LSB = 6;

  localparam int unsigned IMM_W = 16;
  localparam int unsigned SH_W  = 5;
  localparam int unsigned JT_W  = 26;

  function automatic logic [31:0] pack_word(input fmt_e        fmt,
                                            input logic [5:0]  op,
                                            input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [4:0]  rd,
                                            input logic [5:0]  funct,
                                            input logic [31:0] value);
    logic [31:0] w;
    w = '0;
    w[OP_MSB -: 6] = op;
    case (fmt)
      FMT_R: begin
        w[RS_LSB +: 5] = rs;
        w[RT_LSB +: 5] = rt;
        w[RD_LSB +: 5] = rd;
        w[5:0]         = funct;
      end
      FMT_SHIFT: begin
        w[RT_LSB +: 5]    = rt;
        w[RD_LSB +: 5]    = rd;
        w[SH_LSB +: SH_W] = value[SH_W-1:0];
        w[5:0]            = funct;
      end
      FMT_I: begin
        w[RS_LSB +: 5]  = rs;
        w[RT_LSB +: 5]  = rt;
        w[IMM_W-1:0]    = value[IMM_W-1:0];
      end
      default: w[JT_W-1:0] = value[JT_W-1:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_field_encoder_if.sv
// Field-bundle handshake plus instruction-memory write bus.
// mem_rdata exists only when INSTR_ENCODER_READBACK_EN is defined.
interface instr_field_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [31:0]       value;
  logic              imm_signed;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
`ifdef INSTR_ENCODER_READBACK_EN
  logic [31:0]       mem_rdata;

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, funct, value, imm_signed, mem_ack, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, funct, value, imm_signed, mem_ack, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
`else
  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, funct, value, imm_signed, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, funct, value, imm_signed, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/instr_field_encoder_range_check.sv
// Accepts a value only if the CPU-side extender would reproduce it exactly.
module instr_range_check
  import instr_field_encoder_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic        imm_signed_i,
  input  logic [31:0] value_i,
  output logic        ok_o
);

  always_comb begin
    ok_o = 1'b0;
    unique case (fmt_i)
      FMT_R:     ok_o = 1'b1;
      FMT_SHIFT: ok_o = (value_i[31:SH_W] == '0);
      // Signed immediates: bits above the sign bit must replicate it.
      FMT_I:     ok_o = imm_signed_i ? (&value_i[31:IMM_W-1] | ~|value_i[31:IMM_W-1])
                                     : (value_i[31:IMM_W] == '0);
      FMT_J:     ok_o = (value_i[31:JT_W] == '0);
      default:   ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_field_encoder.sv
// Packs decoded fields into MIPS words and writes them to sequential memory addresses.
// Optional INSTR_ENCODER_READBACK_EN adds a read-back verify step after each write.
module instr_field_encoder
  import instr_field_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_field_encoder_if.slave  bus,
  output logic                  err_o,
  input  logic                  err_clr_i,
  output logic                  full_o,
  output logic [ADDR_W:0]       count_o
);

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  fmt_e        fmt_q;
  logic [5:0]  op_q, funct_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [31:0] value_q;
  logic        imm_signed_q;

  logic accept, range_ok, advance;

  instr_range_check u_range_check (
    .fmt_i        (fmt_q),
    .imm_signed_i (imm_signed_q),
    .value_i      (value_q),
    .ok_o         (range_ok)
  );

  assign full_o       = (count_q == DepthCnt);
  assign bus.in_ready = (state_q == StIdle) && !full_o;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.mem_we   = (state_q == StWrite);
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign err_o        = err_q;
  assign count_o      = count_q;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    advance = 1'b0;
    case (state_q)
      StIdle: if (accept) state_d = StPack;
      StPack: begin
        if (range_ok) begin
          wdata_d = pack_word(fmt_q, op_q, rs_q, rt_q, rd_q, funct_q, value_q);
          state_d = StWrite;
        end else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StWrite: begin
        if (bus.mem_ack) begin
`ifdef INSTR_ENCODER_READBACK_EN
          state_d = StVerify;
`else
          advance = 1'b1;
          state_d = StIdle;
`endif
        end
      end
`ifdef INSTR_ENCODER_READBACK_EN
      StVerify: begin
        if (bus.mem_rdata == wdata_q) begin
          advance = 1'b1;
          state_d = StIdle;
        end else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
`endif
      StErr: begin
        if (err_clr_i) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Address saturates on the last word so it never points past DEPTH-1 once full.
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    if (advance) begin
      count_d = count_q + 1'b1;
      addr_d  = (addr_q == LastAddr) ? addr_q : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_q        <= FMT_R;
      op_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      funct_q      <= '0;
      value_q      <= '0;
      imm_signed_q <= 1'b0;
    end else if (accept) begin
      fmt_q        <= fmt_e'(bus.fmt);
      op_q         <= bus.opcode;
      rs_q         <= bus.rs;
      rt_q         <= bus.rt;
      rd_q         <= bus.rd;
      funct_q      <= bus.funct;
      value_q      <= bus.value;
      imm_signed_q <= bus.imm_signed;
    end
  end

endmodule

// File: tb/tb_instr_field_encoder.sv
// Self-checking bench for instr_field_encoder: directed vector table, random bundles
// against an arithmetic reference model, stall, full and mid-write reset sequences.
module tb_instr_field_encoder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 12;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] value;
    logic        sgn;
    logic        exp_ok;
    logic [31:0] exp_word;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic            err;
  logic            err_clr;
  logic            full;
  logic [ADDR_W:0] count;
  logic            corrupt;

  int checks;
  int errors;
  int m_count;
  int m_addr;

  instr_field_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_field_encoder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_o     (err),
    .err_clr_i (err_clr),
    .full_o    (full),
    .count_o   (count)
  );

`ifdef INSTR_ENCODER_READBACK_EN
  assign bus.mem_rdata = bus.mem_wdata ^ {31'b0, corrupt};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: range rules as numeric bounds, packing as weighted field sums.
  function automatic vec_t model(input vec_t vi);
    vec_t        v;
    longint      sv;
    longint unsigned u, w;
    v  = vi;
    u  = longint'(v.value);
    sv = longint'($signed(v.value));
    w  = longint'(v.op) * 64'd67108864;
    case (v.fmt)
      2'd0: begin
        v.exp_ok = 1'b1;
        w += longint'(v.rs) * 2097152 + longint'(v.rt) * 65536 + longint'(v.rd) * 2048
             + longint'(v.funct);
      end
      2'd1: begin
        v.exp_ok = (u < 32);
        w += longint'(v.rt) * 65536 + longint'(v.rd) * 2048 + (u % 32) * 64 + longint'(v.funct);
      end
      2'd2: begin
        v.exp_ok = v.sgn ? (sv >= -32768 && sv <= 32767) : (u < 65536);
        w += longint'(v.rs) * 2097152 + longint'(v.rt) * 65536 + (u % 65536);
      end
      default: begin
        v.exp_ok = (u < 67108864);
        w += u % 67108864;
      end
    endcase
    v.exp_word = w[31:0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.fmt        = v.fmt;
    bus.opcode     = v.op;
    bus.rs         = v.rs;
    bus.rt         = v.rt;
    bus.rd         = v.rd;
    bus.funct      = v.funct;
    bus.value      = v.value;
    bus.imm_signed = v.sgn;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    err_clr      = 1'b0;
    corrupt      = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_count = 0;
    m_addr  = 0;
    @(negedge clk);
  endtask

  task automatic expect_err_and_clear();
    chk("err_set", err, 1);
    chk("err_no_we", bus.mem_we, 0);
    chk("err_addr", bus.mem_addr, m_addr);
    chk("err_count", count, m_count);
    chk("err_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", err, 0);
    chk("err_ready_back", bus.in_ready, 1);
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic do_bundle(input vec_t v, input int ack_wait);
    int n;
    logic [31:0] word0;
    n = 0;
    if (m_count >= DEPTH) begin
      drive(v);
      bus.in_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("full_ready", bus.in_ready, 0);
        chk("full_no_we", bus.mem_we, 0);
      end
      bus.in_valid = 1'b0;
      chk("full_count", count, DEPTH);
      return;
    end
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    drive(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pack_busy", bus.in_ready, 0);
    chk("pack_no_we", bus.mem_we, 0);
    @(negedge clk);
    if (!v.exp_ok) begin
      expect_err_and_clear();
      return;
    end
    chk("we_latency", bus.mem_we, 1);
    chk("wdata", bus.mem_wdata, v.exp_word);
    chk("addr", bus.mem_addr, m_addr);
    word0 = bus.mem_wdata;
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      chk("stall_we", bus.mem_we, 1);
      chk("stall_wdata", bus.mem_wdata, word0);
      chk("stall_addr", bus.mem_addr, m_addr);
      chk("stall_count", count, m_count);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("we_drop", bus.mem_we, 0);
`ifdef INSTR_ENCODER_READBACK_EN
    @(negedge clk);
    if (corrupt) begin
      expect_err_and_clear();
      return;
    end
`endif
    m_count++;
    m_addr = (m_count < DEPTH) ? m_count : DEPTH - 1;
    chk("count", count, m_count);
    chk("addr_next", bus.mem_addr, m_addr);
    chk("full", full, (m_count == DEPTH));
    chk("ready_next", bus.in_ready, (m_count < DEPTH));
    chk("no_err", err, 0);
  endtask

  function automatic logic [31:0] pick_value();
    logic [31:0] edges [12];
    edges = '{32'd31, 32'd32, 32'd32767, 32'd32768, 32'd65535, 32'd65536, 32'hFFFF_8000,
              32'hFFFF_7FFF, 32'h03FF_FFFF, 32'h0400_0000, 32'hFFFF_FFFF, 32'd0};
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 70000));
      default: return edges[$urandom_range(0, 11)];
    endcase
  endfunction

  vec_t vecs [11];
  vec_t rv;

  initial begin
    checks  = 0;
    errors  = 0;
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    drive('{2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 1'b0, 1'b0, 32'd0});

    vecs[0]  = '{2'd2, 6'h08, 5'd1,  5'd2, 5'd0, 6'h00, 32'hFFFF_8000, 1'b1, 1'b1, 32'h2022_8000};
    vecs[1]  = '{2'd2, 6'h08, 5'd1,  5'd2, 5'd0, 6'h00, 32'h0000_8000, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{2'd1, 6'h00, 5'd31, 5'd3, 5'd4, 6'h00, 32'd31,        1'b0, 1'b1, 32'h0003_27C0};
    vecs[3]  = '{2'd1, 6'h00, 5'd0,  5'd3, 5'd4, 6'h00, 32'd32,        1'b0, 1'b0, 32'h0};
    vecs[4]  = '{2'd0, 6'h00, 5'd1,  5'd2, 5'd3, 6'h20, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0022_1820};
    vecs[5]  = '{2'd2, 6'h0C, 5'd3,  5'd4, 5'd0, 6'h00, 32'h0000_FFFF, 1'b0, 1'b1, 32'h3064_FFFF};
    vecs[6]  = '{2'd2, 6'h0C, 5'd3,  5'd4, 5'd0, 6'h00, 32'h0001_0000, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{2'd2, 6'h08, 5'd0,  5'd1, 5'd0, 6'h00, 32'h0000_7FFF, 1'b1, 1'b1, 32'h2001_7FFF};
    vecs[8]  = '{2'd2, 6'h08, 5'd0,  5'd1, 5'd0, 6'h00, 32'hFFFF_7FFF, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{2'd3, 6'h02, 5'd0,  5'd0, 5'd0, 6'h00, 32'h03FF_FFFF, 1'b0, 1'b1, 32'h0BFF_FFFF};
    vecs[10] = '{2'd3, 6'h02, 5'd0,  5'd0, 5'd0, 6'h00, 32'h0400_0000, 1'b0, 1'b0, 32'h0};

    apply_reset();
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);

    for (int i = 0; i < 11; i++) do_bundle(vecs[i], (i == 0) ? 5 : (i % 3));

    // err_clr while idle must not disturb anything.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_idle_err", err, 0);
    chk("clr_idle_ready", bus.in_ready, 1);
    chk("clr_idle_count", count, m_count);

    apply_reset();
    for (int i = 0; i < 40; i++) begin
      rv.fmt   = 2'($urandom_range(0, 3));
      rv.op    = 6'($urandom);
      rv.rs    = 5'($urandom);
      rv.rt    = 5'($urandom);
      rv.rd    = 5'($urandom);
      rv.funct = 6'($urandom);
      rv.value = pick_value();
      rv.sgn   = 1'($urandom);
      rv = model(rv);
      do_bundle(rv, $urandom_range(0, 3));
    end
    while (m_count < DEPTH) begin
      rv = model('{2'd3, 6'h03, 5'd0, 5'd0, 5'd0, 6'd0, 32'($urandom_range(0, 1000)),
                   1'b0, 1'b0, 32'd0});
      do_bundle(rv, 0);
    end
    chk("final_full", full, 1);
    chk("final_ready", bus.in_ready, 0);
    chk("final_count", count, DEPTH);
    chk("final_addr", bus.mem_addr, DEPTH - 1);
    do_bundle(vecs[0], 0);

    // Asynchronous reset while a write is stalled.
    apply_reset();
    do_bundle(vecs[0], 0);
    drive(vecs[5]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midwr_we", bus.mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwr_rst_we", bus.mem_we, 0);
    chk("midwr_rst_addr", bus.mem_addr, 0);
    chk("midwr_rst_wdata", bus.mem_wdata, 0);
    chk("midwr_rst_count", count, 0);
    chk("midwr_rst_full", full, 0);
    chk("midwr_rst_err", err, 0);
    chk("midwr_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n   = 1'b1;
    m_count = 0;
    m_addr  = 0;
    @(negedge clk);
    chk("midwr_no_retry", bus.mem_we, 0);

`ifdef INSTR_ENCODER_READBACK_EN
    do_bundle(vecs[2], 1);
    corrupt = 1'b1;
    do_bundle(vecs[4], 0);
    corrupt = 1'b0;
    chk("rb_count", count, m_count);
    chk("rb_addr", bus.mem_addr, m_addr);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
